// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the source side of the toggle req/ack bus crossing.
// State encodings must match the receiver side.
package cdc_handshake_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_ERROR    = 2'd2
    } tx_state_t;

    // A disabled timeout (0) still needs a 1-bit counter so the vector is never zero-width.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_ack_sync.sv
// Single-bit multi-flop synchronizer that brings the destination's ack toggle into CLK.
module ack_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source half of a 2-phase bus crossing: captures a word, toggles TX_REQ and waits
// for the matching synchronized RX_ACK toggle, flagging a sticky ERR on timeout.
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] SRC_DATA,
    input  logic                 SRC_VALID,
    output logic                 SRC_READY,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 TX_REQ,
    input  logic                 RX_ACK,
    output logic                 DONE,
    output logic                 ERR,
    input  logic                 ERR_CLR
);

    localparam int CNT_WIDTH = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    tx_state_t              state;
    tx_state_t              state_next;
    logic [BUS_WIDTH-1:0]   tx_data_q;
    logic                   tx_req_q;
    logic                   done_q;
    logic                   err_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   load;
    logic                   done_next;
    logic                   err_set;
    logic                   ack_s;

    ack_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (RX_ACK),
        .sync_out (ack_s)
    );

    // The transfer completes when the synchronized ack parity catches up with TX_REQ.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        done_next  = 1'b0;
        err_set    = 1'b0;
        cnt_next   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (SRC_VALID) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_s == tx_req_q) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_next = ST_ERROR;
                    err_set    = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_next = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_ERROR: begin
                if (ack_s == tx_req_q) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            cnt_q  <= cnt_next;
            if (load) begin
                tx_data_q <= SRC_DATA;
                tx_req_q  <= ~tx_req_q;
            end
            // A timeout on the same edge as a clear keeps the flag set.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (ERR_CLR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign SRC_READY = (state == ST_IDLE);
    assign TX_DATA   = tx_data_q;
    assign TX_REQ    = tx_req_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: loopback, streaming, timeout, spurious ack
// and reset, plus a second instance with the timeout disabled.
module tb_cdc_handshake_tx;

    localparam int NS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_b;
    logic [7:0] src_data;
    logic       src_valid;
    logic       loopback;
    logic       rx_ack_manual;
    logic       err_clr;
    wire        src_ready;
    wire  [7:0] tx_data;
    wire        tx_req;
    wire        rx_ack;
    wire        done;
    wire        err;

    logic [7:0] b_data;
    logic       b_valid;
    logic       b_rx_ack;
    wire        b_ready;
    wire  [7:0] b_tx_data;
    wire        b_tx_req;
    wire        b_done;
    wire        b_err;

    int   checks = 0;
    int   errors = 0;
    logic exp_req;

    always #5 clk = ~clk;

    assign rx_ack = loopback ? tx_req : rx_ack_manual;

    cdc_handshake_tx #(
        .BUS_WIDTH      (8),
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .SRC_DATA  (src_data),
        .SRC_VALID (src_valid),
        .SRC_READY (src_ready),
        .TX_DATA   (tx_data),
        .TX_REQ    (tx_req),
        .RX_ACK    (rx_ack),
        .DONE      (done),
        .ERR       (err),
        .ERR_CLR   (err_clr)
    );

    cdc_handshake_tx #(
        .BUS_WIDTH      (8),
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (0)
    ) dut_notimeout (
        .CLK       (clk),
        .RST       (rst_b),
        .SRC_DATA  (b_data),
        .SRC_VALID (b_valid),
        .SRC_READY (b_ready),
        .TX_DATA   (b_tx_data),
        .TX_REQ    (b_tx_req),
        .RX_ACK    (b_rx_ack),
        .DONE      (b_done),
        .ERR       (b_err),
        .ERR_CLR   (1'b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle valid pulse; the caller guarantees the block is in IDLE.
    task automatic applyStimulus(input logic [7:0] data);
        src_data  = data;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        exp_req   = ~exp_req;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int         n;
        int         idx;
        int         done_cnt;
        int         hold_bad;
        int         spurious_dones;
        logic       rdy;
        logic [7:0] last_acc;

        rst           = 1'b0;
        rst_b         = 1'b0;
        src_data      = 8'h00;
        src_valid     = 1'b0;
        loopback      = 1'b0;
        rx_ack_manual = 1'b0;
        err_clr       = 1'b0;
        b_data        = 8'h00;
        b_valid       = 1'b0;
        b_rx_ack      = 1'b0;
        exp_req       = 1'b0;
        repeat (2) tick();
        checkOutput("rst_tx_req", tx_req, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        checkOutput("rst_ready", src_ready, 1);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_done", done, 0);
        rst   = 1'b1;
        rst_b = 1'b1;
        tick();

        // The no-timeout instance gets one word and a stuck ack for the whole run.
        b_data  = 8'h11;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;

        $display("[TB] loopback transfer");
        loopback = 1'b1;
        checkOutput("loop_ready_before", src_ready, 1);
        applyStimulus(8'hA5);
        checkOutput("loop_tx_data", tx_data, 8'hA5);
        checkOutput("loop_tx_req", tx_req, 1);
        checkOutput("loop_ready_busy", src_ready, 0);
        waitDone(n);
        checkOutput("loop_done_latency", n, NS + 1);
        tick();
        checkOutput("loop_one_done", done, 0);
        checkOutput("loop_ready_after", src_ready, 1);

        $display("[TB] streaming 256 words");
        idx       = 0;
        done_cnt  = 0;
        hold_bad  = 0;
        last_acc  = 8'h00;
        src_data  = 8'h00;
        src_valid = 1'b1;
        for (int cyc = 0; cyc < 4000 && done_cnt < 256; cyc++) begin
            rdy = src_ready;
            tick();
            if (rdy && src_valid) begin
                last_acc = src_data;
                idx++;
                exp_req = ~exp_req;
            end
            if (done) begin
                checkOutput("stream_order", tx_data, done_cnt & 8'hFF);
                done_cnt++;
            end
            if (!src_ready && tx_data !== last_acc) hold_bad++;
            if (idx >= 256) src_valid = 1'b0;
            else            src_data  = idx[7:0];
        end
        src_valid = 1'b0;
        checkOutput("stream_dones", done_cnt, 256);
        checkOutput("stream_hold", hold_bad, 0);
        checkOutput("stream_req_parity", tx_req, exp_req);

        $display("[TB] timeout with stuck ack");
        loopback      = 1'b0;
        rx_ack_manual = exp_req;
        tick();
        applyStimulus(8'h3C);
        repeat (15) tick();
        checkOutput("to_err_before", err, 0);
        tick();
        checkOutput("to_err_16th", err, 1);
        checkOutput("to_ready_err", src_ready, 0);
        repeat (5) tick();
        checkOutput("to_data_held", tx_data, 8'h3C);
        rx_ack_manual = exp_req;
        waitDone(n);
        checkOutput("to_late_done", n, NS + 1);
        checkOutput("to_late_ready", src_ready, 1);
        checkOutput("to_err_sticky", err, 1);
        tick();
        checkOutput("to_err_still", err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("to_err_cleared", err, 0);

        $display("[TB] clear and timeout on one edge");
        applyStimulus(8'hC3);
        repeat (15) tick();
        checkOutput("race_err_before", err, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("race_set_wins", err, 1);
        rx_ack_manual = exp_req;
        waitDone(n);
        checkOutput("race_late_done", n, NS + 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("race_cleared", err, 0);

        $display("[TB] spurious ack in IDLE");
        rx_ack_manual  = ~exp_req;
        spurious_dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) spurious_dones++;
        end
        checkOutput("spur_no_done", spurious_dones, 0);
        checkOutput("spur_ready", src_ready, 1);
        checkOutput("spur_req", tx_req, exp_req);
        checkOutput("spur_data", tx_data, 8'hC3);
        rx_ack_manual = exp_req;
        repeat (4) tick();

        $display("[TB] reset in WAIT_ACK");
        applyStimulus(8'h5A);
        repeat (3) tick();
        checkOutput("mid_busy", src_ready, 0);
        rx_ack_manual = 1'b0;
        rst           = 1'b0;
        #1;
        checkOutput("mid_rst_req", tx_req, 0);
        checkOutput("mid_rst_data", tx_data, 0);
        checkOutput("mid_rst_ready", src_ready, 1);
        checkOutput("mid_rst_err", err, 0);
        tick();
        rst     = 1'b1;
        exp_req = 1'b0;

        $display("[TB] long wait with timeout disabled");
        repeat (10000) tick();
        checkOutput("noto_err", b_err, 0);
        checkOutput("noto_busy", b_ready, 0);
        checkOutput("noto_req", b_tx_req, 1);
        checkOutput("noto_data", b_tx_data, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
